ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU. It handles the opcode 0110011 / funct7 0000001 instructions, which the ALU control decoder maps to `nop_`. It accepts one operation per handshake, computes it over 32 iterations (special divides complete early), and returns a one-cycle result pulse. While it is busy, the hazard unit holds IF/ID/EX.

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 24 ++
 rtl/ex_muldiv.sv | 103 ++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
package ex_muldiv_pkg;

   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

   function automatic logic a_signed(input logic [2:0] f3);
      return f3 inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic b_signed(input logic [2:0] f3);
      return f3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add multiply step and one restoring divide step
module muldiv_iter (
   input  logic [63:0] prod,
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] opd,
   output logic [63:0] prod_nxt,
   output logic [31:0] rem_nxt,
   output logic [31:0] quo_nxt
);

   logic [32:0] sum, shifted, trial;

   // multiplier sits in prod low half and shifts out LSB first; dividend shifts out of quo MSB first
   always_comb begin
      sum      = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opd} : 33'd0);
      prod_nxt = {sum, prod[31:1]};
      shifted  = {rem, quo[31]};
      trial    = shifted - {1'b0, opd};
      rem_nxt  = trial[32] ? shifted[31:0] : trial[31:0];
      quo_nxt  = {quo[30:0], ~trial[32]};
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            in_ready,
   output logic            busy,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);

   muldiv_state_t state;
   muldiv_op_t    op;
   logic [4:0]    cnt;
   logic          sa, sb;
   logic [63:0]   prod, prod_nxt, prod_fix;
   logic [31:0]   rem, rem_nxt, quo, quo_nxt, opd;
   logic [31:0]   a_mag, b_mag, spec_val, quo_fix, rem_fix, calc_res;
   logic          acc_sa, acc_sb, spec;

   muldiv_iter u_iter (
      .prod     (prod),
      .rem      (rem),
      .quo      (quo),
      .opd      (opd),
      .prod_nxt (prod_nxt),
      .rem_nxt  (rem_nxt),
      .quo_nxt  (quo_nxt)
   );

   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = (state == DONE) & ~flush;

   // accept-time operand decode and final sign fix-up of the last iteration's values
   always_comb begin
      acc_sa   = rs1_data[31] & a_signed(funct3);
      acc_sb   = rs2_data[31] & b_signed(funct3);
      a_mag    = acc_sa ? -rs1_data : rs1_data;
      b_mag    = acc_sb ? -rs2_data : rs2_data;
      spec     = funct3[2] & ((rs2_data == '0) |
                 (~funct3[0] & (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF)));
      spec_val = (rs2_data == '0) ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'h0 : 32'h8000_0000);
      prod_fix = (sa ^ sb) ? -prod_nxt : prod_nxt;
      quo_fix  = (sa ^ sb) ? -quo_nxt : quo_nxt;
      rem_fix  = sa ? -rem_nxt : rem_nxt;
      calc_res = (op == OP_MUL) ? prod_fix[31:0] : ~op[2] ? prod_fix[63:32] : ~op[1] ? quo_fix : rem_fix;
   end

   // control FSM, iteration datapath registers and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         op     <= OP_MUL;
         cnt    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         prod   <= '0;
         rem    <= '0;
         quo    <= '0;
         opd    <= '0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op    <= muldiv_op_t'(funct3);
               sa    <= acc_sa;
               sb    <= acc_sb;
               cnt   <= '0;
               prod  <= {32'h0, b_mag};
               rem   <= '0;
               quo   <= a_mag;
               opd   <= funct3[2] ? b_mag : a_mag;
               state <= spec ? DONE : CALC;
               if (spec) result <= spec_val;
            end
            CALC: begin
               prod <= prod_nxt;
               rem  <= rem_nxt;
               quo  <= quo_nxt;
               cnt  <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  result <= calc_res;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
